// File: rtl/width_split_if.sv
// Byte-lane stream bundle for width_split: 3-lane input side and 2-lane output side.
// master drives input words and the output-ready; slave is the unpacker itself.
interface width_split_if #(
  parameter int QUAN_BITS = 8
);
  logic [3*QUAN_BITS-1:0] i_bytes_in;
  logic                   i_bytes_valid;
  logic                   o_bytes_ready;
  logic [2*QUAN_BITS-1:0] o_bytes_out;
  logic                   o_bytes_valid;
  logic                   i_out_ready;

  modport master (
    output i_bytes_in,
    output i_bytes_valid,
    output i_out_ready,
    input  o_bytes_ready,
    input  o_bytes_out,
    input  o_bytes_valid
  );

  modport slave (
    input  i_bytes_in,
    input  i_bytes_valid,
    input  i_out_ready,
    output o_bytes_ready,
    output o_bytes_out,
    output o_bytes_valid
  );
endinterface

// File: rtl/width_split.sv
// 24-bit -> 16-bit byte-lane unpacker with a 5-lane holding buffer, lane 0 leaves first.
// Optional residue padding on i_flush is built when WIDTH_SPLIT_FLUSH_EN is defined.
`ifndef QUAN_BITS
`define QUAN_BITS 8
`endif

module width_split #(
  parameter int QUAN_BITS = `QUAN_BITS
) (
  input  logic        s_clk,
  input  logic        s_rst,
`ifdef WIDTH_SPLIT_FLUSH_EN
  input  logic        i_flush,
`endif
  width_split_if.slave bus,
  output logic [2:0]  o_level
);

  localparam int LANES = 5;

  logic [QUAN_BITS-1:0]   lane_q [LANES];
  logic [QUAN_BITS-1:0]   lane_d [LANES];
  logic [QUAN_BITS-1:0]   lane_sh_s [LANES];
  logic [2:0]             cnt_q, cnt_d, cnt_sh_s;
  logic                   pad_q, pad_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic [2*QUAN_BITS-1:0] out_q, out_d;
  logic                   emit_s, accept_s;
  logic [QUAN_BITS-1:0]   in_l0_s, in_l1_s, in_l2_s;

  assign emit_s   = valid_q & bus.i_out_ready;
  assign accept_s = bus.i_bytes_valid & ready_q;
  assign in_l0_s  = bus.i_bytes_in[QUAN_BITS-1:0];
  assign in_l1_s  = bus.i_bytes_in[2*QUAN_BITS-1:QUAN_BITS];
  assign in_l2_s  = bus.i_bytes_in[3*QUAN_BITS-1:2*QUAN_BITS];

  assign bus.o_bytes_valid = valid_q;
  assign bus.o_bytes_ready = ready_q;
  assign bus.o_bytes_out   = out_q;
  assign o_level           = cnt_q;

  // Emit first drops the two oldest lanes; lanes above cnt are always kept zero.
  always_comb begin
    lane_sh_s = lane_q;
    cnt_sh_s  = cnt_q;
    if (emit_s) begin
      lane_sh_s[0] = lane_q[2];
      lane_sh_s[1] = lane_q[3];
      lane_sh_s[2] = lane_q[4];
      lane_sh_s[3] = '0;
      lane_sh_s[4] = '0;
      if (pad_q && (cnt_q == 3'd1)) begin
        cnt_sh_s = 3'd0;
      end else begin
        cnt_sh_s = cnt_q - 3'd2;
      end
    end else begin
      lane_sh_s = lane_q;
      cnt_sh_s  = cnt_q;
    end
  end

  // Accepted word lands right above the post-emit fill level.
  always_comb begin
    lane_d = lane_sh_s;
    for (int i = 0; i < LANES; i++) begin
      if (accept_s && (3'(i) == cnt_sh_s)) begin
        lane_d[i] = in_l0_s;
      end else if (accept_s && (3'(i) == cnt_sh_s + 3'd1)) begin
        lane_d[i] = in_l1_s;
      end else if (accept_s && (3'(i) == cnt_sh_s + 3'd2)) begin
        lane_d[i] = in_l2_s;
      end else begin
        lane_d[i] = lane_sh_s[i];
      end
    end
    cnt_d = cnt_sh_s + (accept_s ? 3'd3 : 3'd0);
  end

  // Pad flag and the output decode of the next state, so every output comes from a flop.
  always_comb begin
`ifdef WIDTH_SPLIT_FLUSH_EN
    if (pad_q && (cnt_d == 3'd0)) begin
      pad_d = 1'b0;
    end else if (!pad_q && i_flush && (cnt_d != 3'd0)) begin
      pad_d = 1'b1;
    end else begin
      pad_d = pad_q;
    end
`else
    pad_d = 1'b0;
`endif
    valid_d = (cnt_d >= 3'd2) || (pad_d && (cnt_d == 3'd1));
    ready_d = (cnt_d <= 3'd2) && !pad_d;
    if (pad_d && (cnt_d == 3'd1)) begin
      out_d = {{QUAN_BITS{1'b0}}, lane_d[0]};
    end else begin
      out_d = {lane_d[1], lane_d[0]};
    end
  end

  // State and registered outputs; reset discards buffered lanes at once.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
      cnt_q   <= 3'd0;
      pad_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      out_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_width_split.sv
// Scoreboard bench for width_split: stimulus pushes expected words, a negedge monitor pops them.
// Flush checks are compiled in only when WIDTH_SPLIT_FLUSH_EN is defined.
module tb_width_split;
  localparam int QB = 8;

  logic       s_clk = 1'b0;
  logic       s_rst = 1'b1;
  logic       i_flush;
  logic [2:0] o_level;

  width_split_if #(.QUAN_BITS(QB)) bus ();

  width_split #(.QUAN_BITS(QB)) dut (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
`ifdef WIDTH_SPLIT_FLUSH_EN
    .i_flush (i_flush),
`endif
    .bus     (bus.slave),
    .o_level (o_level)
  );

  always #5 s_clk = ~s_clk;

  logic [15:0] exp_q [$];
  logic [7:0]  lane_m [$];
  logic [15:0] mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge s_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every word the DUT hands over must match the head of the scoreboard.
  always @(negedge s_clk) begin
    if (!s_rst && bus.o_bytes_valid && bus.i_out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h expected none", bus.o_bytes_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_word", {16'h0, bus.o_bytes_out}, {16'h0, mon_e});
      end
    end
  end

  task automatic send(input logic [23:0] w, input bit mdl);
    int t;
    logic [7:0] lo, hi;
    t = 0;
    bus.i_bytes_in    = w;
    bus.i_bytes_valid = 1'b1;
    @(negedge s_clk);
    while (!bus.o_bytes_ready && t < 50) begin
      @(negedge s_clk);
      t++;
    end
    if (!bus.o_bytes_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready got 0 expected 1 for word 0x%0h", w);
      bus.i_bytes_valid = 1'b0;
    end else if (mdl) begin
      lane_m.push_back(w[7:0]);
      lane_m.push_back(w[15:8]);
      lane_m.push_back(w[23:16]);
      while (lane_m.size() >= 2) begin
        lo = lane_m.pop_front();
        hi = lane_m.pop_front();
        exp_q.push_back({hi, lo});
      end
    end
    @(posedge s_clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge s_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge s_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 expected less");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit ok;
    bus.i_bytes_in    = 24'h0;
    bus.i_bytes_valid = 1'b0;
    bus.i_out_ready   = 1'b1;
    i_flush           = 1'b0;
    repeat (2) @(posedge s_clk);
    #1;
    s_rst = 1'b0;

    // 1: reset state
    chk("rst_ready", {31'h0, bus.o_bytes_ready}, 32'h1);
    chk("rst_valid", {31'h0, bus.o_bytes_valid}, 32'h0);
    chk("rst_level", {29'h0, o_level}, 32'h0);
    chk("rst_out",   {16'h0, bus.o_bytes_out}, 32'h0);

    // 2: two words split into three
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    exp_q.push_back(16'h0605);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b0);
    bus.i_bytes_valid = 1'b0;
    drain();
    chk("t2_level", {29'h0, o_level}, 32'h0);
    chk("t2_valid", {31'h0, bus.o_bytes_valid}, 32'h0);

    // 3: back-to-back random stream
    lane_m.delete();
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      send(24'($urandom), 1'b1);
    end
    bus.i_bytes_valid = 1'b0;
    drain();
    ok = ((cyc - t0) <= 420) && ((cyc - t0) >= 300);
    chk("t3_cycles_in_range", {31'h0, ok}, 32'h1);
    chk("t3_level", {29'h0, o_level}, 32'h0);

    // 4: downstream stall
    bus.i_out_ready = 1'b0;
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    exp_q.push_back(16'h0605);
    send(24'h030201, 1'b0);
    bus.i_bytes_in    = 24'h060504;
    bus.i_bytes_valid = 1'b1;
    repeat (4) @(posedge s_clk);
    #1;
    chk("t4_level", {29'h0, o_level}, 32'h3);
    chk("t4_ready", {31'h0, bus.o_bytes_ready}, 32'h0);
    chk("t4_valid", {31'h0, bus.o_bytes_valid}, 32'h1);
    chk("t4_hold",  {16'h0, bus.o_bytes_out}, 32'h0201);
    @(posedge s_clk);
    #1;
    chk("t4_hold2", {16'h0, bus.o_bytes_out}, 32'h0201);
    bus.i_out_ready = 1'b1;
    send(24'h060504, 1'b0);
    bus.i_bytes_valid = 1'b0;
    drain();
    chk("t4_level_end", {29'h0, o_level}, 32'h0);

    // 5: odd residue
    exp_q.push_back(16'hBBAA);
    send(24'hCCBBAA, 1'b0);
    bus.i_bytes_valid = 1'b0;
    drain();
    chk("t5_level", {29'h0, o_level}, 32'h1);
    chk("t5_valid", {31'h0, bus.o_bytes_valid}, 32'h0);
`ifdef WIDTH_SPLIT_FLUSH_EN
    exp_q.push_back(16'h00CC);
    i_flush = 1'b1;
    @(posedge s_clk);
    #1;
    i_flush = 1'b0;
    drain();
    chk("t5_flush_level", {29'h0, o_level}, 32'h0);
    chk("t5_flush_ready", {31'h0, bus.o_bytes_ready}, 32'h1);
    exp_q.push_back(16'h2211);
    send(24'h332211, 1'b0);
    bus.i_bytes_valid = 1'b0;
    drain();
`endif

    // 6: reset with four lanes buffered, then restart
    bus.i_out_ready = 1'b0;
    send(24'h665544, 1'b0);
    bus.i_bytes_valid = 1'b0;
    chk("t6_level_before", {29'h0, o_level}, 32'h4);
    #2;
    s_rst = 1'b1;
    #1;
    chk("t6_rst_level", {29'h0, o_level}, 32'h0);
    chk("t6_rst_valid", {31'h0, bus.o_bytes_valid}, 32'h0);
    chk("t6_rst_out",   {16'h0, bus.o_bytes_out}, 32'h0);
    chk("t6_rst_ready", {31'h0, bus.o_bytes_ready}, 32'h1);
    exp_q.delete();
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    bus.i_out_ready = 1'b1;
    exp_q.push_back(16'h0201);
    send(24'h030201, 1'b0);
    bus.i_bytes_valid = 1'b0;
    drain();
    chk("t6_restart_level", {29'h0, o_level}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
